pic_fetch_seq: RTL and testbench
================================

Name: pic_fetch_seq

Overview:
- Instruction fetch/sequencer stage for the structural PIC core.
- Latches the 12-bit word that program memory returns for the program counter's current 9-bit address into an instruction register (IR).
- Decodes the control-flow instructions and drives the counter's `load`, `push` and `pop` strobes, the jump target, and the CALL literal onto the shared 8-bit data bus.
- Implements PIC two-cycle branch semantics: after any taken control transfer, the next fetched word is flushed and replaced by a NOP.

Parameters:
- CNT_W, 16, width of the retired-instruction counter (wraps modulo 2^CNT_W).
- NOP_WORD, 12'h000, word loaded into IR on reset and flush.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- instr_in  in  12  program-memory read data for the current program-counter address.
- skip_req  in  1  ALU condition result for the executing skip instruction (bit-test true, or decrement/increment result zero).
- ir_out  out  12  currently executing instruction.
- ir_valid  out  1  ir_out is a real instruction (0 = fill/flush bubble).
- pc_load  out  1  to program counter `load`: GOTO executing.
- pc_push  out  1  to program counter `push`: CALL executing.
- pc_pop  out  1  to program counter `pop`: RETLW executing.
- addr_target  out  9  to program counter `addr_in`; always ir_out[8:0].
- data_bus  out  8  tri-state; drives ir_out[7:0] when pc_push=1, otherwise 8'bz.
- retired  out  CNT_W  count of instructions executed with ir_valid=1.

Behaviour:
- Reset values: IR=NOP_WORD, ir_valid=0, state=FILL, retired=0. Consequently pc_load/pc_push/pc_pop=0 and data_bus=z.
- States: FILL, EXEC, FLUSH. IR and retired are registered; decode outputs are combinational from IR, gated by ir_valid.
- FILL -> EXEC on the first edge after reset release: IR<=instr_in (word at address 0), ir_valid<=1.
- In EXEC, a transfer is taken when any of the following holds:
  - GOTO (ir[11:9]=3'b101);
  - CALL (ir[11:8]=4'b1001);
  - RETLW (ir[11:8]=4'b1000);
  - a skip-class instruction with skip_req=1 this cycle. Skip class: BTFSC ir[11:8]=0110, BTFSS 0111, DECFSZ ir[11:6]=001011, INCFSZ 001111.
- EXEC, transfer taken: next edge IR<=NOP_WORD, ir_valid<=0, state<=FLUSH.
- EXEC, no transfer: next edge IR<=instr_in, ir_valid<=1, stay EXEC.
- FLUSH: next edge IR<=instr_in, ir_valid<=1, state<=EXEC. No transfer can be taken in FLUSH, so two back-to-back taken transfers are impossible.
- Strobes: pc_load=valid&GOTO, pc_push=valid&CALL, pc_pop=valid&RETLW. They are mutually exclusive by encoding.
- skip_req is ignored unless IR is a valid skip-class instruction.
- Latency: a strobe is visible in the same cycle the instruction sits in IR; the program counter acts on the following edge, which is the same edge that flushes.
- retired increments by 1 on each edge where ir_valid=1, wrapping to 0 after all-ones. The flushed branch itself counts; the bubble does not.
- A bubble (FILL/FLUSH) is a NOP with ir_valid=0. Downstream stages must not commit state on it.
- Reset asserted mid-operation: outputs return to their reset values immediately without waiting for an edge. Restart is FILL from address 0.
- The block never stalls; the program counter advances every cycle it is not redirected.

Decomposition:
- Shared package pic_isa_pkg holds:
  - opcode patterns/masks (GOTO, CALL, RETLW, BTFSC, BTFSS, DECFSZ, INCFSZ);
  - the NOP constant;
  - the fetch-state enum {FILL, EXEC, FLUSH}.
- Sub-module pic_cf_decode (purely combinational) maps a 12-bit word to is_goto, is_call, is_retlw, is_skip. It is reused by the later full instruction decoder.

Test Plan:
- Reset then release; instr_in=12'h0A5 -> cycle0 ir_valid=0; cycle1 ir_out=0A5, ir_valid=1; retired=1 after cycle1 edge.
- GOTO 12'hB23 executing -> pc_load=1, addr_target=9'h123; next cycle ir_out=000, ir_valid=0; following cycle ir_valid=1 with new word.
- CALL 12'h95A -> pc_push=1, data_bus=8'h5A, one bubble; in all other cycles data_bus=8'bz.
- BTFSC 12'h613 with skip_req=1 -> bubble next cycle, no strobes. Same with skip_req=0 -> no bubble, next word valid. skip_req=1 with a non-skip instruction (MOVWF) -> no bubble.
- Assert reset during FLUSH following RETLW -> pc_pop, ir_valid and retired clear immediately; next two cycles behave as the FILL sequence.
- Run 2^CNT_W valid instructions (CNT_W=4 override, 16 instructions) -> retired wraps to 0.

Source files
------------

// File: rtl/pic_isa_pkg.sv
// Shared PIC ISA definitions: control-flow opcode patterns, NOP word, fetch states.
package pic_isa_pkg;

  localparam int unsigned INSTR_W = 12;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DATA_W  = 8;

  localparam logic [INSTR_W-1:0] NOP = 12'h000;

  // Each opcode is recognised by (word & MASK) == PAT.
  localparam logic [INSTR_W-1:0] GOTO_MASK   = 12'hE00;
  localparam logic [INSTR_W-1:0] GOTO_PAT    = 12'hA00;
  localparam logic [INSTR_W-1:0] CALL_MASK   = 12'hF00;
  localparam logic [INSTR_W-1:0] CALL_PAT    = 12'h900;
  localparam logic [INSTR_W-1:0] RETLW_MASK  = 12'hF00;
  localparam logic [INSTR_W-1:0] RETLW_PAT   = 12'h800;
  localparam logic [INSTR_W-1:0] BTFSC_MASK  = 12'hF00;
  localparam logic [INSTR_W-1:0] BTFSC_PAT   = 12'h600;
  localparam logic [INSTR_W-1:0] BTFSS_MASK  = 12'hF00;
  localparam logic [INSTR_W-1:0] BTFSS_PAT   = 12'h700;
  localparam logic [INSTR_W-1:0] DECFSZ_MASK = 12'hFC0;
  localparam logic [INSTR_W-1:0] DECFSZ_PAT  = 12'h2C0;
  localparam logic [INSTR_W-1:0] INCFSZ_MASK = 12'hFC0;
  localparam logic [INSTR_W-1:0] INCFSZ_PAT  = 12'h3C0;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EXEC  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  function automatic logic op_match(input logic [INSTR_W-1:0] word,
                                    input logic [INSTR_W-1:0] mask,
                                    input logic [INSTR_W-1:0] pat);
    return (word & mask) == pat;
  endfunction

endpackage

// File: rtl/pic_cf_decode.sv
// Control-flow decode of one instruction word; purely combinational.
module pic_cf_decode
  import pic_isa_pkg::*;
(
  input  logic [11:0] word,
  output logic        is_goto,
  output logic        is_call,
  output logic        is_retlw,
  output logic        is_skip
);

  // Opcode classification; skip class covers the four conditional-skip opcodes.
  always_comb begin
    is_goto  = op_match(word, GOTO_MASK,  GOTO_PAT);
    is_call  = op_match(word, CALL_MASK,  CALL_PAT);
    is_retlw = op_match(word, RETLW_MASK, RETLW_PAT);
    is_skip  = op_match(word, BTFSC_MASK,  BTFSC_PAT)
             | op_match(word, BTFSS_MASK,  BTFSS_PAT)
             | op_match(word, DECFSZ_MASK, DECFSZ_PAT)
             | op_match(word, INCFSZ_MASK, INCFSZ_PAT);
  end

endmodule

// File: rtl/pic_fetch_seq.sv
// Instruction fetch/sequencer: IR, two-cycle branch flush, PC strobes, retired count.
module pic_fetch_seq
  import pic_isa_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter logic [11:0] NOP_WORD = 12'h000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [11:0]      instr_in,
  input  logic             skip_req,
  output logic [11:0]      ir_out,
  output logic             ir_valid,
  output logic             pc_load,
  output logic             pc_push,
  output logic             pc_pop,
  output logic [8:0]       addr_target,
  output logic [7:0]       data_bus,
  output logic [CNT_W-1:0] retired
);

  fetch_state_t     state_q, state_d;
  logic [11:0]      ir_q, ir_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] retired_q;
  logic             is_goto, is_call, is_retlw, is_skip;
  logic             transfer;

  pic_cf_decode u_cf_decode (
    .word     (ir_q),
    .is_goto  (is_goto),
    .is_call  (is_call),
    .is_retlw (is_retlw),
    .is_skip  (is_skip)
  );

  // State, IR and valid flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      ir_q    <= NOP_WORD;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: a taken transfer in EXEC replaces the next fetched word with a bubble.
  always_comb begin
    state_d  = state_q;
    ir_d     = instr_in;
    valid_d  = 1'b1;
    transfer = valid_q & (state_q == EXEC)
             & (is_goto | is_call | is_retlw | (is_skip & skip_req));
    case (state_q)
      FILL:  state_d = EXEC;
      EXEC: begin
        if (transfer) begin
          state_d = FLUSH;
          ir_d    = NOP_WORD;
          valid_d = 1'b0;
        end
      end
      FLUSH: state_d = EXEC;
      default: begin
        state_d = FILL;
        ir_d    = NOP_WORD;
        valid_d = 1'b0;
      end
    endcase
  end

  // Retired-instruction counter; bubbles are not counted, the flushed branch is.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      retired_q <= '0;
    else if (valid_q)
      retired_q <= retired_q + CNT_W'(1);
  end

  // Program-counter strobes, gated so a bubble never redirects the PC.
  always_comb begin
    pc_load = valid_q & is_goto;
    pc_push = valid_q & is_call;
    pc_pop  = valid_q & is_retlw;
  end

  assign ir_out      = ir_q;
  assign ir_valid    = valid_q;
  assign addr_target = ir_q[8:0];
  assign retired     = retired_q;
  assign data_bus    = pc_push ? ir_q[7:0] : 8'bz;

endmodule

// File: tb/tb_pic_fetch_seq.sv
// Directed scoreboard bench for pic_fetch_seq (counter narrowed to 4 bits).
module tb_pic_fetch_seq;

  localparam int unsigned CW = 4;

  logic          clock;
  logic          reset;
  logic [11:0]   instr_in;
  logic          skip_req;
  logic [11:0]   ir_out;
  logic          ir_valid;
  logic          pc_load;
  logic          pc_push;
  logic          pc_pop;
  logic [8:0]    addr_target;
  wire  [7:0]    data_bus;
  logic [CW-1:0] retired;

  typedef struct {
    logic [11:0]   ir;
    logic          valid;
    logic [2:0]    strb;   // {load, push, pop}
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] exp_ret = '0;
  logic          prev_v  = 1'b0;

  pic_fetch_seq #(.CNT_W(CW), .NOP_WORD(12'h000)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_in    (instr_in),
    .skip_req    (skip_req),
    .ir_out      (ir_out),
    .ir_valid    (ir_valid),
    .pc_load     (pc_load),
    .pc_push     (pc_push),
    .pc_pop      (pc_pop),
    .addr_target (addr_target),
    .data_bus    (data_bus),
    .retired     (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    logic [7:0] ebus;
    ebus = e.strb[1] ? e.ir[7:0] : 8'bz;
    chk({tag, ".ir"},      {4'h0, ir_out},      {4'h0, e.ir});
    chk({tag, ".valid"},   {15'h0, ir_valid},   {15'h0, e.valid});
    chk({tag, ".strb"},    {13'h0, pc_load, pc_push, pc_pop}, {13'h0, e.strb});
    chk({tag, ".addr"},    {7'h0, addr_target}, {7'h0, e.ir[8:0]});
    chk({tag, ".bus"},     {8'h0, data_bus},    {8'h0, ebus});
    chk({tag, ".retired"}, {12'h0, retired},    {12'h0, e.ret});
  endtask

  // Drive one cycle's inputs, queue the expectation for after the edge, then compare.
  task automatic step(input string tag, input logic [11:0] instr, input logic skip,
                      input logic [11:0] eir, input logic ev, input logic [2:0] estrb);
    exp_t e;
    instr_in = instr;
    skip_req = skip;
    exp_ret  = exp_ret + {{(CW-1){1'b0}}, prev_v};
    prev_v   = ev;
    e.ir = eir; e.valid = ev; e.strb = estrb; e.ret = exp_ret;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check_outputs(tag, e);
  endtask

  initial begin
    exp_t z;
    z.ir = 12'h000; z.valid = 1'b0; z.strb = 3'b000; z.ret = '0;

    reset    = 1'b1;
    instr_in = 12'h0A5;
    skip_req = 1'b0;
    #1;
    check_outputs("reset", z);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_outputs("fill0", z);

    step("fill1",   12'h0A5, 1'b0, 12'h0A5, 1'b1, 3'b000);
    step("goto",    12'hB23, 1'b0, 12'hB23, 1'b1, 3'b100);
    step("goto_fl", 12'h0C1, 1'b0, 12'h000, 1'b0, 3'b000);
    step("goto_nx", 12'h0C1, 1'b0, 12'h0C1, 1'b1, 3'b000);
    step("call",    12'h95A, 1'b0, 12'h95A, 1'b1, 3'b010);
    step("call_fl", 12'h0C2, 1'b0, 12'h000, 1'b0, 3'b000);
    step("btfsc",   12'h613, 1'b0, 12'h613, 1'b1, 3'b000);
    step("btfsc_t", 12'h0C3, 1'b1, 12'h000, 1'b0, 3'b000);
    step("btfsc2",  12'h613, 1'b0, 12'h613, 1'b1, 3'b000);
    step("btfsc_n", 12'h0C4, 1'b0, 12'h0C4, 1'b1, 3'b000);
    step("movwf",   12'h021, 1'b0, 12'h021, 1'b1, 3'b000);
    step("movwf_s", 12'h0C5, 1'b1, 12'h0C5, 1'b1, 3'b000);
    step("decfsz",  12'h2C5, 1'b0, 12'h2C5, 1'b1, 3'b000);
    step("decfsz_t",12'h0C6, 1'b1, 12'h000, 1'b0, 3'b000);
    step("incfsz",  12'h3C7, 1'b0, 12'h3C7, 1'b1, 3'b000);
    step("incfsz_t",12'h0C8, 1'b1, 12'h000, 1'b0, 3'b000);
    step("btfss",   12'h705, 1'b0, 12'h705, 1'b1, 3'b000);
    step("btfss_n", 12'h0C9, 1'b0, 12'h0C9, 1'b1, 3'b000);
    step("retlw",   12'h8AB, 1'b0, 12'h8AB, 1'b1, 3'b001);
    step("retlw_fl",12'h0CA, 1'b0, 12'h000, 1'b0, 3'b000);

    // Asynchronous reset in the middle of the flush cycle.
    #2;
    reset = 1'b1;
    #1;
    check_outputs("midreset", z);
    sb.delete();
    exp_ret = '0;
    prev_v  = 1'b0;
    @(negedge clock);
    reset    = 1'b0;
    instr_in = 12'h0A5;
    #1;
    check_outputs("refill0", z);
    step("refill1", 12'h0A5, 1'b0, 12'h0A5, 1'b1, 3'b000);
    step("refill2", 12'h0CB, 1'b0, 12'h0CB, 1'b1, 3'b000);

    // 15 more valid instructions bring the count to 16 mod 16.
    for (int i = 0; i < 15; i++)
      step("nop_run", 12'h000, 1'b0, 12'h000, 1'b1, 3'b000);
    chk("wrap", {12'h0, retired}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
